// File: rtl/synth_voice_pkg.sv
// Shared constants and FSM state type for the FM synth voice allocator.
// Imported by voice_age_rank and voice_allocator_16.
package synth_voice_pkg;

    localparam int NUM_VOICES = 16;
    localparam int AGE_BITS   = 4;

    typedef enum logic {
        ST_IDLE,
        ST_UPDATE
    } state_t;

endpackage

// File: rtl/voice_age_rank.sv
// Age ranking for 16 voices: 0 = newest, 15 = oldest.
// Ranks always form a permutation of 0..15.
module voice_age_rank
    import synth_voice_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                upd_i,
    input  logic [AGE_BITS-1:0] idx_i,
    output logic [AGE_BITS-1:0] oldest_o
);

    logic [AGE_BITS-1:0] rank_q [NUM_VOICES];
    logic [AGE_BITS-1:0] rank_d [NUM_VOICES];
    logic [AGE_BITS-1:0] cur;

    always_comb begin
        cur = rank_q[idx_i];
        for (int i = 0; i < NUM_VOICES; i++) begin
            rank_d[i] = rank_q[i];
            if (upd_i) begin
                if (AGE_BITS'(i) == idx_i) begin
                    rank_d[i] = '0;
                end else if (rank_q[i] < cur) begin
                    rank_d[i] = rank_q[i] + AGE_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        oldest_o = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_q[i] == {AGE_BITS{1'b1}}) begin
                oldest_o = AGE_BITS'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i] <= AGE_BITS'(i);
            end
        end else begin
            rank_q <= rank_d;
        end
    end

endmodule

// File: rtl/voice_allocator_16.sv
// 16-voice note allocator: retrigger, free-slot, then oldest-voice policy.
// Define VOICE_STEAL_EN to steal the oldest voice when all are gated.
module voice_allocator_16
    import synth_voice_pkg::*;
#(
    parameter int NOTE_BITS = 7,
    parameter int VEL_BITS  = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ev_valid,
    output logic                           ev_ready,
    input  logic                           ev_on,
    input  logic [NOTE_BITS-1:0]           ev_note,
    input  logic [VEL_BITS-1:0]            ev_vel,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
    output logic [NUM_VOICES*VEL_BITS-1:0]  voice_vel,
    output logic [NUM_VOICES-1:0]          voice_gate,
    output logic [NUM_VOICES-1:0]          voice_trig,
    output logic                           ev_dropped
);

    state_t state_q, state_d;
    logic   ready_q, ready_d;
    logic   acc;
    logic   on_q;
    logic [NOTE_BITS-1:0] ev_note_q;
    logic [VEL_BITS-1:0]  ev_vel_q;

    logic [NOTE_BITS-1:0] note_q [NUM_VOICES];
    logic [NOTE_BITS-1:0] note_d [NUM_VOICES];
    logic [VEL_BITS-1:0]  vel_q  [NUM_VOICES];
    logic [VEL_BITS-1:0]  vel_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic drop_q, drop_d;

    logic hit, free, sel_ok;
    logic [AGE_BITS-1:0] hit_idx, free_idx, sel, oldest;

    assign acc = (state_q == ST_IDLE) && ev_valid && ready_q;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (gate_q[i] && note_q[i] == ev_note_q) begin
                hit     = 1'b1;
                hit_idx = AGE_BITS'(i);
            end
            if (!gate_q[i]) begin
                free     = 1'b1;
                free_idx = AGE_BITS'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        vel_d   = vel_q;
        gate_d  = gate_q;
        trig_d  = '0;
        drop_d  = 1'b0;
        sel_ok  = 1'b0;
        sel     = hit ? hit_idx : (free ? free_idx : oldest);
        unique case (state_q)
            ST_IDLE: begin
                if (acc) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
                if (on_q) begin
`ifdef VOICE_STEAL_EN
                    sel_ok = 1'b1;
`else
                    sel_ok = hit | free;
                    drop_d = !(hit | free);
`endif
                    if (sel_ok) begin
                        note_d[sel] = ev_note_q;
                        vel_d[sel]  = ev_vel_q;
                        gate_d[sel] = 1'b1;
                        trig_d[sel] = 1'b1;
                    end
                end else begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (gate_q[i] && note_q[i] == ev_note_q) begin
                            gate_d[i] = 1'b0;
                        end
                    end
                end
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    voice_age_rank u_rank (
        .clk      (clk),
        .rst_n    (rst_n),
        .upd_i    (sel_ok),
        .idx_i    (sel),
        .oldest_o (oldest)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            on_q      <= 1'b0;
            ev_note_q <= '0;
            ev_vel_q  <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
            end
            gate_q <= '0;
            trig_q <= '0;
            drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            note_q  <= note_d;
            vel_q   <= vel_d;
            gate_q  <= gate_d;
            trig_q  <= trig_d;
            drop_q  <= drop_d;
            if (acc) begin
                on_q      <= ev_on;
                ev_note_q <= ev_note;
                ev_vel_q  <= ev_vel;
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[g*NOTE_BITS +: NOTE_BITS] = note_q[g];
        assign voice_vel[g*VEL_BITS +: VEL_BITS]    = vel_q[g];
    end

    assign ev_ready   = ready_q;
    assign voice_gate = gate_q;
    assign voice_trig = trig_q;
    assign ev_dropped = drop_q;

endmodule

// File: tb/tb_voice_allocator_16.sv
// Directed scoreboard bench for voice_allocator_16.
// Honours VOICE_STEAL_EN the same way the design does.
module tb_voice_allocator_16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ev_valid = 1'b0;
    logic         ev_ready;
    logic         ev_on = 1'b0;
    logic [6:0]   ev_note = '0;
    logic [6:0]   ev_vel = '0;
    logic [111:0] voice_note;
    logic [111:0] voice_vel;
    logic [15:0]  voice_gate;
    logic [15:0]  voice_trig;
    logic         ev_dropped;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string        tag;
        logic [15:0]  gate;
        logic [15:0]  trig;
        logic         drop;
        logic [111:0] note;
        logic [111:0] vel;
    } exp_t;

    exp_t sbq[$];

    logic [6:0] m_note [16];
    logic [6:0] m_vel  [16];
    logic [15:0] m_gate;
    int          m_rank [16];

    voice_allocator_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .voice_note (voice_note),
        .voice_vel  (voice_vel),
        .voice_gate (voice_gate),
        .voice_trig (voice_trig),
        .ev_dropped (ev_dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_note[i] = '0;
            m_vel[i]  = '0;
            m_rank[i] = i;
        end
        m_gate = '0;
    endtask

    task automatic model_snap(input string tag, output exp_t e);
        e.tag  = tag;
        e.gate = m_gate;
        e.trig = '0;
        e.drop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e.note[i*7 +: 7] = m_note[i];
            e.vel[i*7 +: 7]  = m_vel[i];
        end
    endtask

    task automatic model_apply(input logic on, input logic [6:0] n,
                               input logic [6:0] v, input string tag,
                               output exp_t e);
        int  v_idx = -1;
        logic [15:0] trig = '0;
        logic drop = 1'b0;
        if (on) begin
            for (int i = 0; i < 16 && v_idx < 0; i++)
                if (m_gate[i] && m_note[i] == n) v_idx = i;
            for (int i = 0; i < 16 && v_idx < 0; i++)
                if (!m_gate[i]) v_idx = i;
`ifdef VOICE_STEAL_EN
            for (int i = 0; i < 16 && v_idx < 0; i++)
                if (m_rank[i] == 15) v_idx = i;
`endif
            if (v_idx < 0) begin
                drop = 1'b1;
            end else begin
                int r = m_rank[v_idx];
                for (int j = 0; j < 16; j++)
                    if (m_rank[j] < r) m_rank[j]++;
                m_rank[v_idx] = 0;
                m_note[v_idx] = n;
                m_vel[v_idx]  = v;
                m_gate[v_idx] = 1'b1;
                trig[v_idx]   = 1'b1;
            end
        end else begin
            for (int i = 0; i < 16; i++)
                if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
        end
        model_snap(tag, e);
        e.trig = trig;
        e.drop = drop;
    endtask

    task automatic compare(input exp_t e);
        chk({e.tag, ".gate"}, voice_gate, e.gate);
        chk({e.tag, ".trig"}, voice_trig, e.trig);
        chk({e.tag, ".drop"}, ev_dropped, e.drop);
        chk({e.tag, ".note"}, voice_note, e.note);
        chk({e.tag, ".vel"},  voice_vel,  e.vel);
    endtask

    task automatic send(input logic on, input logic [6:0] n,
                        input logic [6:0] v, input string tag);
        exp_t e;
        int   w = 0;
        @(negedge clk);
        while (!ev_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ".rdy"}, ev_ready, 1);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = n;
        ev_vel   = v;
        model_apply(on, n, v, tag, e);
        sbq.push_back(e);
        @(posedge clk);
        #1 ev_valid = 1'b0;
        @(posedge clk);
        #1 compare(sbq.pop_front());
        @(posedge clk);
        #1;
        chk({tag, ".trig_clr"}, voice_trig, 0);
        chk({tag, ".drop_clr"}, ev_dropped, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        ev_valid = 1'b0;
        model_reset();
        #2;
        chk("rst.ready", ev_ready, 0);
        chk("rst.gate", voice_gate, 0);
        chk("rst.trig", voice_trig, 0);
        chk("rst.note", voice_note, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel.ready0", ev_ready, 0);
        @(posedge clk);
        #1 chk("rel.ready1", ev_ready, 1);
    endtask

    initial begin
        exp_t e;
        logic [5:0] rp;

        model_reset();
        do_reset();

        send(1, 60, 100, "on60");
        chk("on60.v0note", voice_note[6:0], 60);

        do_reset();
        send(1, 60, 90, "c.on60");
        send(1, 64, 90, "c.on64");
        send(1, 67, 90, "c.on67");
        send(0, 64, 0, "c.off64");
        chk("c.gates", voice_gate, 16'h0005);
        chk("c.v1note", voice_note[13:7], 64);

        do_reset();
        send(1, 60, 100, "r.on60a");
        send(1, 60, 20, "r.on60b");
        chk("r.v0vel", voice_vel[6:0], 20);
        chk("r.gate", voice_gate, 16'h0001);

        do_reset();
        for (int k = 0; k < 16; k++) send(1, 7'(40 + k), 7'(k + 1), "fill");
        send(1, 70, 99, "steal");
`ifdef VOICE_STEAL_EN
        chk("steal.v0note", voice_note[6:0], 70);
`else
        chk("steal.v0note", voice_note[6:0], 40);
`endif
        send(1, 71, 99, "steal2");

        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rp[5-k]  = ev_ready;
            ev_valid = 1'b1;
            ev_on    = 1'b1;
            ev_note  = 7'(80 + k);
            ev_vel   = 7'(50 + k);
        end
        @(negedge clk);
        ev_valid = 1'b0;
        chk("hold.ready", rp, 6'b101010);
        model_apply(1, 80, 50, "hold", e);
        model_apply(1, 82, 52, "hold", e);
        model_apply(1, 84, 54, "hold", e);
        e.trig = '0;
        @(posedge clk);
        #1 compare(e);

        do_reset();
        @(negedge clk);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 60;
        ev_vel   = 100;
        @(posedge clk);
        #1 ev_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ru.gate", voice_gate, 0);
        chk("ru.trig", voice_trig, 0);
        @(posedge clk);
        #1 chk("ru.trig2", voice_trig, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("ru.ready0", ev_ready, 0);
        @(posedge clk);
        #1 chk("ru.ready1", ev_ready, 1);
        @(posedge clk);
        #1;
        model_snap("ru.final", e);
        compare(e);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
